// File: rtl/hex_data_rx.sv
// UART 8N1 receiver that parses lines of ASCII hex digits into 32-bit words on a valid/ready port.
// Optional stop-bit framing check: define HEX_DATA_RX_STOPCHK_EN.
module hex_data_rx #(
  parameter int unsigned UART_SETUP = 217
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_uart_rx,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_err,
  output logic        o_overrun
);

  localparam int unsigned CW = $clog2(UART_SETUP);
  localparam logic [CW-1:0] FULL_CNT = CW'(UART_SETUP - 1);
  localparam logic [CW-1:0] HALF_CNT = CW'(UART_SETUP / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {P_EMPTY, P_DIGITS, P_DISCARD} p_state_t;

  logic          rx_meta, rx_s;
  rx_state_t     rx_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          byte_stb;
  logic          frame_err;
  logic          start_ok;

  p_state_t      p_state;
  logic [31:0]   acc;
  logic [3:0]    dcnt;
  logic          is_hex, is_eol, is_ws, word_done;
  logic [3:0]    nibble;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef HEX_DATA_RX_STOPCHK_EN
  // After a framing error the line must return high before a new start bit is armed.
  logic rx_armed;
  assign start_ok = rx_armed & ~rx_s;
`else
  assign start_ok  = ~rx_s;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rx_state  <= RX_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      byte_stb  <= 1'b0;
`ifdef HEX_DATA_RX_STOPCHK_EN
      frame_err <= 1'b0;
      rx_armed  <= 1'b1;
`endif
    end else begin
      byte_stb  <= 1'b0;
`ifdef HEX_DATA_RX_STOPCHK_EN
      frame_err <= 1'b0;
`endif
      case (rx_state)
        RX_IDLE: begin
`ifdef HEX_DATA_RX_STOPCHK_EN
          if (rx_s) rx_armed <= 1'b1;
`endif
          if (start_ok) begin
            rx_state <= RX_START;
            baud_cnt <= HALF_CNT;
          end
        end
        RX_START: begin
          if (baud_cnt == '0) begin
            if (!rx_s) begin
              rx_state <= RX_DATA;
              baud_cnt <= FULL_CNT;
              bit_idx  <= '0;
            end else begin
              rx_state <= RX_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_DATA: begin
          if (baud_cnt == '0) begin
            shreg    <= {rx_s, shreg[7:1]};
            baud_cnt <= FULL_CNT;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
            else                 bit_idx  <= bit_idx + 3'd1;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        RX_STOP: begin
          if (baud_cnt == '0) begin
            rx_state <= RX_IDLE;
`ifdef HEX_DATA_RX_STOPCHK_EN
            if (rx_s) begin
              byte_stb <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              rx_armed  <= 1'b0;
            end
`else
            byte_stb <= 1'b1;
`endif
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_comb begin
    is_hex = 1'b1;
    nibble = '0;
    if (shreg >= 8'h30 && shreg <= 8'h39)
      nibble = shreg[3:0];
    else if ((shreg >= 8'h41 && shreg <= 8'h46) || (shreg >= 8'h61 && shreg <= 8'h66))
      nibble = shreg[3:0] + 4'd9;
    else
      is_hex = 1'b0;
  end

  assign is_eol    = (shreg == 8'h0A) || (shreg == 8'h0D);
  assign is_ws     = (shreg == 8'h20) || (shreg == 8'h09);
  assign word_done = byte_stb && is_eol && (p_state == P_DIGITS);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      p_state   <= P_EMPTY;
      acc       <= '0;
      dcnt      <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_err     <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_err     <= 1'b0;
      o_overrun <= 1'b0;

      // A completed word may replace one being accepted in the same cycle.
      if (word_done) begin
        if (!o_valid || i_ready) begin
          o_data  <= acc;
          o_valid <= 1'b1;
        end else begin
          o_overrun <= 1'b1;
        end
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
      end

      if (frame_err) begin
        o_err   <= 1'b1;
        p_state <= P_DISCARD;
      end else if (byte_stb) begin
        case (p_state)
          P_EMPTY, P_DIGITS: begin
            if (is_hex) begin
              if (dcnt == 4'd8) begin
                o_err   <= 1'b1;
                p_state <= P_DISCARD;
              end else begin
                acc     <= {acc[27:0], nibble};
                dcnt    <= dcnt + 4'd1;
                p_state <= P_DIGITS;
              end
            end else if (is_eol) begin
              acc     <= '0;
              dcnt    <= '0;
              p_state <= P_EMPTY;
            end else if (!(is_ws && p_state == P_EMPTY)) begin
              o_err   <= 1'b1;
              p_state <= P_DISCARD;
            end
          end
          P_DISCARD: begin
            if (is_eol) begin
              acc     <= '0;
              dcnt    <= '0;
              p_state <= P_EMPTY;
            end
          end
          default: p_state <= P_EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hex_data_rx.sv
// Randomised line-level bench for hex_data_rx; expected words come from a string-level parse model.
module tb_hex_data_rx;

  localparam int unsigned BAUD = 16;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_uart_rx = 1'b1;
  logic        i_ready = 1'b1;
  logic        o_valid;
  logic [31:0] o_data;
  logic        o_err;
  logic        o_overrun;

  hex_data_rx #(.UART_SETUP(BAUD)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_uart_rx (i_uart_rx),
    .i_ready   (i_ready),
    .o_valid   (o_valid),
    .o_data    (o_data),
    .o_err     (o_err),
    .o_overrun (o_overrun)
  );

  always #5 i_clk = ~i_clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int unsigned obs_err = 0, exp_err = 0, obs_ovr = 0, both_cnt = 0;

  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_valid && i_ready) obs_q.push_back(o_data);
      if (o_err) obs_err++;
      if (o_overrun) obs_ovr++;
      if (o_err && o_overrun) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    i_uart_rx = 1'b0;
    tick(BAUD);
    for (int unsigned k = 0; k < 8; k++) begin
      i_uart_rx = b[k];
      tick(BAUD);
    end
    i_uart_rx = stop;
    tick(BAUD);
    i_uart_rx = 1'b1;
  endtask

  function automatic int hexval(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    return -1;
  endfunction

  // Line-level rule: optional leading blanks, then 1..8 hex digits and nothing else.
  task automatic model_line(input logic [7:0] ln[$]);
    int unsigned i = 0;
    logic [31:0] v = '0;
    while (i < ln.size() && (ln[i] == 8'h20 || ln[i] == 8'h09)) i++;
    if (i == ln.size()) return;
    if (ln.size() - i > 8) begin
      exp_err++;
      return;
    end
    for (int unsigned j = i; j < ln.size(); j++) begin
      if (hexval(ln[j]) < 0) begin
        exp_err++;
        return;
      end
      v = v * 16 + 32'(hexval(ln[j]));
    end
    exp_q.push_back(v);
  endtask

  task automatic model_bytes(input logic [7:0] q[$]);
    logic [7:0] ln[$];
    foreach (q[i]) begin
      if (q[i] == 8'h0A || q[i] == 8'h0D) begin
        model_line(ln);
        ln.delete();
      end else begin
        ln.push_back(q[i]);
      end
    end
  endtask

  task automatic run_bytes(input logic [7:0] q[$]);
    model_bytes(q);
    foreach (q[i]) begin
      send_byte(q[i], 1'b1);
      tick($urandom_range(0, 3));
    end
  endtask

  task automatic run_str(input string s);
    logic [7:0] q[$];
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    run_bytes(q);
  endtask

  task automatic score(input string tag);
    tick(40);
    check({tag, " words"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s word%0d", tag, i), obs_q[i], exp_q[i]);
    check({tag, " errs"}, 32'(obs_err), 32'(exp_err));
    check({tag, " overruns"}, 32'(obs_ovr), 32'd0);
    obs_q.delete();
    exp_q.delete();
    obs_err = 0;
    exp_err = 0;
    obs_ovr = 0;
  endtask

  task automatic rand_line(output logic [7:0] q[$]);
    logic [7:0] bad[5] = '{8'h67, 8'h78, 8'h20, 8'h5A, 8'h2C};
    int unsigned nd, v, bad_pos, t;
    q.delete();
    repeat ($urandom_range(0, 2)) q.push_back(($urandom_range(0, 1) != 0) ? 8'h20 : 8'h09);
    nd = $urandom_range(0, 9);
    bad_pos = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 8) : 99;
    for (int unsigned k = 0; k < nd; k++) begin
      v = $urandom_range(0, 15);
      if (k == bad_pos) q.push_back(bad[$urandom_range(0, 4)]);
      else if (v < 10) q.push_back(8'(48 + v));
      else if ($urandom_range(0, 1) != 0) q.push_back(8'(55 + v));
      else q.push_back(8'(87 + v));
    end
    t = $urandom_range(0, 2);
    if (t != 1) q.push_back(8'h0D);
    if (t != 0) q.push_back(8'h0A);
  endtask

  initial begin
    logic [7:0] q[$];
    logic [7:0] seven;

    tick(4);
    check("reset valid", {31'd0, o_valid}, 32'd0);
    check("reset data", o_data, 32'd0);
    check("reset err", {31'd0, o_err}, 32'd0);
    check("reset overrun", {31'd0, o_overrun}, 32'd0);
    i_reset_n = 1'b1;
    tick(4);

    run_str("DEADBEEF\n");
    score("deadbeef");
    run_str("  1a\015\n");
    score("crlf");
    run_str("123456789\n5\n");
    score("nine digits");
    run_str("12g4\nFF\n");
    score("bad char");

    // A short low glitch must be rejected at the start-bit recheck.
    i_uart_rx = 1'b0;
    tick(3);
    i_uart_rx = 1'b1;
    tick(BAUD * 2);
    run_str("A\n");
    score("glitch");

    // Back-pressure: the second word is dropped while the first is pending.
    i_ready = 1'b0;
    model_bytes('{8'h31, 8'h0A});
    send_byte("1", 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte("2", 1'b1);
    send_byte(8'h0A, 1'b1);
    tick(40);
    check("ovr valid held", {31'd0, o_valid}, 32'd1);
    check("ovr data held", o_data, 32'd1);
    check("ovr pulses", 32'(obs_ovr), 32'd1);
    check("ovr none taken", 32'(obs_q.size()), 32'd0);
    obs_ovr = 0;
    i_ready = 1'b1;
    tick(2);
    check("ovr valid drop", {31'd0, o_valid}, 32'd0);
    score("overrun accept");

    // Reset in the middle of bit 4 of '7' discards the partial byte.
    seven = "7";
    i_uart_rx = 1'b0;
    tick(BAUD);
    for (int unsigned k = 0; k < 4; k++) begin
      i_uart_rx = seven[k];
      tick(BAUD);
    end
    i_uart_rx = seven[4];
    tick(BAUD / 2);
    i_reset_n = 1'b0;
    tick(2);
    i_uart_rx = 1'b1;
    tick(2);
    check("midreset valid", {31'd0, o_valid}, 32'd0);
    i_reset_n = 1'b1;
    tick(BAUD * 2);
    run_str("3\n");
    score("mid reset");

`ifdef HEX_DATA_RX_STOPCHK_EN
    send_byte("5", 1'b0);
    tick(BAUD);
    exp_err++;
    run_str("\n4\n");
    score("framing");
`endif

    for (int unsigned n = 0; n < 20; n++) begin
      rand_line(q);
      run_bytes(q);
    end
    score("random");

    check("err with overrun", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hex_data_rx.md
Name: hex_data_rx

Overview:
- UART-side receiver, the inbound counterpart of the hex word transmitter used by the data debugger.
- Deserialises 8N1 UART bytes from a host and parses lines of ASCII hex digits into 32-bit words.
- Presents each word on a valid/ready interface for loading registers or driving stimulus from a PC.
- Everything runs on one clock domain; the only asynchronous input is the serial line, which is synchronised internally.

Parameters:
- UART_SETUP, 217: clocks per baud period (CLOCK_RATE_HZ/BAUD_RATE, 25 MHz / 115200); minimum legal value 4.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  synchronous reset, active-low, sampled on rising i_clk
- i_uart_rx  input  1  serial line, idle high, asynchronous
- i_ready  input  1  consumer accepts o_data when high with o_valid
- o_valid  output  1  word available; held until accepted
- o_data  output  32  parsed word, zero-extended
- o_err  output  1  one-cycle pulse: parse error (bad character or more than 8 digits)
- o_overrun  output  1  one-cycle pulse: completed word dropped because o_valid was still pending

Behaviour:
- Reset (i_reset_n low at a clock edge):
  - o_valid, o_err and o_overrun go to 0; o_data goes to 0.
  - The receive FSM goes to IDLE and the parser goes to EMPTY.
  - The synchroniser flops are set to 1.
  - Reset mid-byte or mid-line discards all partial data.
- Synchroniser: 2-FF on i_uart_rx; all logic uses the synchronised bit rx_s.
- Receive FSM: IDLE, START, DATA, STOP, driven by a baud counter.
  - IDLE: rx_s==0 -> START, with counter = UART_SETUP/2 - 1.
  - START: at counter 0, re-sample. If rx_s==0 -> DATA (counter = UART_SETUP-1, bit index 0); otherwise it is a glitch -> IDLE.
  - DATA: at counter 0, shift rx_s in LSB first and reload the counter. After bit 7 -> STOP.
  - STOP: at counter 0, sample the stop bit. Raise internal byte_stb for one cycle and go to IDLE in the same cycle, so back-to-back bytes are accepted.
- Parser (updates on the cycle after byte_stb):
  - Hex digits 0-9, a-f, A-F: acc <= {acc[27:0], nibble}; digit count +1; EMPTY -> DIGITS.
  - A 9th digit -> o_err pulse; state -> DISCARD.
  - Space (0x20) or tab (0x09) in EMPTY: ignored. In DIGITS: parse error.
  - LF (0x0A) or CR (0x0D):
    - In DIGITS: word complete; acc and count clear; state -> EMPTY.
    - In EMPTY: ignored, so CR-LF pairs and blank lines produce nothing.
    - In DISCARD: -> EMPTY with no output.
  - Any other byte in EMPTY or DIGITS: o_err pulse; state -> DISCARD.
  - In DISCARD, all bytes except LF/CR are ignored.
- Output handshake:
  - Word complete with o_valid==0, or with o_valid & i_ready in the same cycle: o_data <= acc, o_valid <= 1.
  - Word complete with o_valid==1 and i_ready==0: word dropped, o_overrun pulse, o_data unchanged.
  - o_valid & i_ready with no new word: o_valid <= 0. o_data holds its value.
- Latency: o_valid rises 2 cycles after the terminator byte's stop-bit sample (1 cycle for byte_stb, 1 cycle for the parser).
- Fewer than 8 digits: the word is right-aligned, e.g. "1a" gives 32'h0000001a.
- o_err and o_overrun never assert in the same cycle, because they are caused by different bytes.

Optional Feature:
- Macro: HEX_DATA_RX_STOPCHK_EN.
- Defined: a stop bit sampled as 0 is a framing error.
  - The byte is discarded, o_err pulses, and the parser goes to DISCARD.
  - The FSM then waits in IDLE until rx_s==1 before arming for a new start bit.
- Undefined: the stop-bit value is ignored and every byte is delivered as received.

Test Plan:
- UART_SETUP=16, send "DEADBEEF\n", i_ready=1 -> o_valid for 1 cycle, o_data=32'hDEADBEEF, 2 cycles after the LF stop sample; no o_err.
- Send "  1a\r\n" -> a single word 32'h0000001A; the trailing LF produces nothing.
- Send "123456789\n", then "5\n" -> o_err after the 9th digit, no word for the first line; the second line gives 32'h00000005.
- Send "12g4\n" -> o_err on 'g', no word; a subsequent "FF\n" gives 32'h000000FF.
- Hold i_ready=0, send "1\n2\n" -> o_data=1 stays valid; o_overrun pulses at the second LF. Raise i_ready -> 1 accepted, o_valid drops.
- Assert i_reset_n=0 during bit 4 of '7', then send "3\n" -> no output from the partial line; the word is 32'h00000003. With HEX_DATA_RX_STOPCHK_EN, a byte with stop=0 -> o_err, and the line is discarded.
